// File: rtl/gpio_pkg.sv
// Shared register map and bus constants for the GPIO port controller.
package gpio_pkg;

   localparam int GPIO_BUS_W = 32;

   typedef logic [3:0] gpio_addr_t;

   localparam gpio_addr_t GPIO_DIR_OFF         = 4'h0;
   localparam gpio_addr_t GPIO_OUT_OFF         = 4'h1;
   localparam gpio_addr_t GPIO_IN_OFF          = 4'h2;
   localparam gpio_addr_t GPIO_OUT_SET_OFF     = 4'h3;
   localparam gpio_addr_t GPIO_OUT_CLR_OFF     = 4'h4;
   localparam gpio_addr_t GPIO_OUT_TGL_OFF     = 4'h5;
   localparam gpio_addr_t GPIO_IRQ_RISE_EN_OFF = 4'h6;
   localparam gpio_addr_t GPIO_IRQ_FALL_EN_OFF = 4'h7;
   localparam gpio_addr_t GPIO_IRQ_STATUS_OFF  = 4'h8;

endpackage

// File: rtl/gpio_sync_edge.sv
// Pad input synchroniser, optional per-pin debounce (GPIO_DEBOUNCE_EN) and
// edge detector with a post-reset warm-up window that masks spurious edges.
module gpio_sync_edge
   import gpio_pkg::*;
#(
   parameter int WIDTH           = 8,
   parameter int NUM_SYNC        = 2,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] pad,
   input  logic [WIDTH-1:0] dir,
   output logic [WIDTH-1:0] filt,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall
);

`ifdef GPIO_DEBOUNCE_EN
   localparam int DB_ON = 1;
`else
   localparam int DB_ON = 0;
`endif
   localparam int WARM   = NUM_SYNC + 1 + DB_ON * DEBOUNCE_CYCLES;
   localparam int WARM_W = $clog2(WARM + 1);
   localparam logic [WARM_W-1:0] WARM_END = WARM_W'(WARM);

   logic [WIDTH-1:0]  sync_q [NUM_SYNC];
   logic [WIDTH-1:0]  sync_in;
   logic [WIDTH-1:0]  prev_p1;
   logic [WARM_W-1:0] warm_cnt;
   logic              warm_done;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NUM_SYNC; k++) sync_q[k] <= '0;
      end else begin
         sync_q[0] <= pad;
         for (int k = 1; k < NUM_SYNC; k++) sync_q[k] <= sync_q[k-1];
      end
   end

   assign sync_in = sync_q[NUM_SYNC-1];

`ifdef GPIO_DEBOUNCE_EN
   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   logic [DB_W-1:0]  db_cnt [WIDTH];
   logic [WIDTH-1:0] filt_q;

   // A pin only follows sync_in after DEBOUNCE_CYCLES consecutive disagreeing samples.
   always_ff @(posedge clk) begin
      if (rst) begin
         filt_q <= '0;
         for (int i = 0; i < WIDTH; i++) db_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (sync_in[i] != filt_q[i]) begin
               if (db_cnt[i] == DB_LAST) begin
                  filt_q[i] <= sync_in[i];
                  db_cnt[i] <= '0;
               end else begin
                  db_cnt[i] <= db_cnt[i] + 1'b1;
               end
            end else begin
               db_cnt[i] <= '0;
            end
         end
      end
   end

   assign filt = filt_q;
`else
   assign filt = sync_in;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         warm_cnt <= '0;
         prev_p1  <= '0;
      end else begin
         if (warm_cnt != WARM_END) warm_cnt <= warm_cnt + 1'b1;
         prev_p1 <= filt;
      end
   end

   assign warm_done = (warm_cnt == WARM_END);

   // Output pins never raise events.
   assign rise = filt & ~prev_p1 & ~dir & {WIDTH{warm_done}};
   assign fall = ~filt & prev_p1 & ~dir & {WIDTH{warm_done}};

endmodule

// File: rtl/gpio_port_ctrl.sv
// Parametrised GPIO port: bus registers, atomic output ops, edge interrupts.
// Optional input debounce is enabled by defining GPIO_DEBOUNCE_EN.
module gpio_port_ctrl
   import gpio_pkg::*;
#(
   parameter int WIDTH           = 8,
   parameter int NUM_SYNC        = 2,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_i,
   input  logic                  we_i,
   input  logic [3:0]            addr_i,
   input  logic [GPIO_BUS_W-1:0] wdata_i,
   output logic [GPIO_BUS_W-1:0] rdata_o,
   output logic                  ack_o,
   input  logic [WIDTH-1:0]      gpio_in_i,
   output logic [WIDTH-1:0]      gpio_out_o,
   output logic [WIDTH-1:0]      gpio_oe_o,
   output logic                  irq_o
);

   logic [WIDTH-1:0]      dir_q, out_q, rise_en_q, fall_en_q, status_q;
   logic [WIDTH-1:0]      filt_in, rise, fall, wdata_w, w1c_mask;
   logic                  wr_p0, rd_p0;
   logic [GPIO_BUS_W-1:0] rd_mux_p0, rdata_p1;
   logic                  ack_p1, irq_p1;
   logic                  unused_wdata;

   gpio_sync_edge #(
      .WIDTH           (WIDTH),
      .NUM_SYNC        (NUM_SYNC),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_sync_edge (
      .clk  (clk),
      .rst  (rst),
      .pad  (gpio_in_i),
      .dir  (dir_q),
      .filt (filt_in),
      .rise (rise),
      .fall (fall)
   );

   assign wr_p0        = req_i & we_i;
   assign rd_p0        = req_i & ~we_i;
   assign wdata_w      = wdata_i[WIDTH-1:0];
   assign unused_wdata = ^wdata_i;
   assign w1c_mask     = (wr_p0 && addr_i == GPIO_IRQ_STATUS_OFF) ? wdata_w : '0;

   always_comb begin
      rd_mux_p0 = '0;
      case (addr_i)
         GPIO_DIR_OFF:         rd_mux_p0 = GPIO_BUS_W'(dir_q);
         GPIO_OUT_OFF:         rd_mux_p0 = GPIO_BUS_W'(out_q);
         GPIO_IN_OFF:          rd_mux_p0 = GPIO_BUS_W'(filt_in);
         GPIO_IRQ_RISE_EN_OFF: rd_mux_p0 = GPIO_BUS_W'(rise_en_q);
         GPIO_IRQ_FALL_EN_OFF: rd_mux_p0 = GPIO_BUS_W'(fall_en_q);
         GPIO_IRQ_STATUS_OFF:  rd_mux_p0 = GPIO_BUS_W'(status_q);
         default:              rd_mux_p0 = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dir_q     <= '0;
         out_q     <= '0;
         rise_en_q <= '0;
         fall_en_q <= '0;
      end else if (wr_p0) begin
         case (addr_i)
            GPIO_DIR_OFF:         dir_q     <= wdata_w;
            GPIO_OUT_OFF:         out_q     <= wdata_w;
            GPIO_OUT_SET_OFF:     out_q     <= out_q | wdata_w;
            GPIO_OUT_CLR_OFF:     out_q     <= out_q & ~wdata_w;
            GPIO_OUT_TGL_OFF:     out_q     <= out_q ^ wdata_w;
            GPIO_IRQ_RISE_EN_OFF: rise_en_q <= wdata_w;
            GPIO_IRQ_FALL_EN_OFF: fall_en_q <= wdata_w;
            default: ;
         endcase
      end
   end

   // New events are OR-ed in after the W1C mask, so a same-cycle event wins.
   always_ff @(posedge clk) begin
      if (rst) status_q <= '0;
      else     status_q <= (status_q & ~w1c_mask) | (rise & rise_en_q) | (fall & fall_en_q);
   end

   // p0 -> p1: bus response and interrupt are registered one cycle after sampling.
   always_ff @(posedge clk) begin
      if (rst) begin
         ack_p1   <= 1'b0;
         rdata_p1 <= '0;
         irq_p1   <= 1'b0;
      end else begin
         ack_p1   <= req_i;
         rdata_p1 <= rd_p0 ? rd_mux_p0 : '0;
         irq_p1   <= |status_q;
      end
   end

   assign ack_o      = ack_p1;
   assign rdata_o    = rdata_p1;
   assign irq_o      = irq_p1;
   assign gpio_out_o = out_q;
   assign gpio_oe_o  = dir_q;

endmodule

// File: tb/tb_gpio_port_ctrl.sv
// Directed bench for gpio_port_ctrl with a scoreboard queue of expected read data.
module tb_gpio_port_ctrl;

   localparam int WIDTH    = 8;
   localparam int NUM_SYNC = 2;
`ifdef GPIO_DEBOUNCE_EN
   localparam int DB_LAT = 16;
`else
   localparam int DB_LAT = 0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        req_i, we_i;
   logic [3:0]  addr_i;
   logic [31:0] wdata_i, rdata_o;
   logic        ack_o;
   logic [WIDTH-1:0] gpio_in_i, gpio_out_o, gpio_oe_o;
   logic        irq_o;

   int          tests = 0;
   int          fails = 0;
   logic [31:0] exp_q[$];
   logic        req_s;

   always #5 clk = ~clk;

   gpio_port_ctrl #(
      .WIDTH           (WIDTH),
      .NUM_SYNC        (NUM_SYNC),
      .DEBOUNCE_CYCLES (16)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_i      (req_i),
      .we_i       (we_i),
      .addr_i     (addr_i),
      .wdata_i    (wdata_i),
      .rdata_o    (rdata_o),
      .ack_o      (ack_o),
      .gpio_in_i  (gpio_in_i),
      .gpio_out_o (gpio_out_o),
      .gpio_oe_o  (gpio_oe_o),
      .irq_o      (irq_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // One clock: sample at the edge, check the bus response 1 time unit later.
   task automatic step();
      req_s = req_i & ~rst;
      @(posedge clk);
      #1;
      check("ack", {31'b0, ack_o}, {31'b0, req_s});
      if (req_s) begin
         if (exp_q.size() > 0) begin
            check("rdata", rdata_o, exp_q.pop_front());
         end else begin
            tests++;
            fails++;
            $error("FAIL rdata: observed ack with empty scoreboard, expected no ack");
         end
      end else begin
         check("rdata_idle", rdata_o, 32'h0);
      end
      req_i   = 1'b0;
      we_i    = 1'b0;
      addr_i  = 4'h0;
      wdata_i = 32'h0;
   endtask

   task automatic bus(input logic we, input logic [3:0] a, input logic [31:0] d, input logic [31:0] exp);
      req_i   = 1'b1;
      we_i    = we;
      addr_i  = a;
      wdata_i = d;
      exp_q.push_back(exp);
      step();
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      bus(1'b1, a, d, 32'h0);
   endtask

   task automatic rd(input logic [3:0] a, input logic [31:0] exp);
      bus(1'b0, a, 32'h0, exp);
   endtask

   initial begin
      rst = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = 4'h0; wdata_i = 32'h0; gpio_in_i = '0;
      repeat (2) step();
      // Write attempted while in reset: no ack, no effect.
      req_i = 1'b1; we_i = 1'b1; addr_i = 4'h1; wdata_i = 32'hFF;
      step();
      step();
      check("rst_out", 32'(gpio_out_o), 32'h0);
      check("rst_oe", 32'(gpio_oe_o), 32'h0);
      check("rst_irq", {31'b0, irq_o}, 32'h0);
      rst = 1'b0;

      for (int a = 0; a < 16; a++) rd(4'(a), 32'h0);

      wr(4'h0, 32'hFFFF_FF0F);
      check("oe_dir", 32'(gpio_oe_o), 32'h0F);
      wr(4'h1, 32'hA5);
      check("out_a5", 32'(gpio_out_o), 32'hA5);
      wr(4'h3, 32'h10);
      check("out_set", 32'(gpio_out_o), 32'hB5);
      wr(4'h4, 32'h01);
      check("out_clr", 32'(gpio_out_o), 32'hB4);
      wr(4'h5, 32'h80);
      check("out_tgl", 32'(gpio_out_o), 32'h34);
      rd(4'h1, 32'h34);
      rd(4'h0, 32'h0F);
      rd(4'h3, 32'h0);
      rd(4'h5, 32'h0);

      // Rising edge on input pin 0.
      wr(4'h0, 32'h0);
      wr(4'h6, 32'h01);
      gpio_in_i = 8'h01;
      repeat (2 + DB_LAT) step();
      rd(4'h2, 32'h01);
      check("irq_before", {31'b0, irq_o}, 32'h0);
      rd(4'h8, 32'h01);
      check("irq_set", {31'b0, irq_o}, 32'h1);
      wr(4'h8, 32'h01);
      check("irq_hold", {31'b0, irq_o}, 32'h1);
      step();
      check("irq_clr", {31'b0, irq_o}, 32'h0);

      // Falling edge sets status; disabling fall enable keeps it.
      wr(4'h7, 32'h01);
      gpio_in_i = 8'h00;
      repeat (4 + DB_LAT) step();
      check("irq_fall", {31'b0, irq_o}, 32'h1);
      wr(4'h7, 32'h00);
      rd(4'h8, 32'h01);

      // Rise reaches the detector on the same edge as the W1C.
      gpio_in_i = 8'h01;
      repeat (2 + DB_LAT) step();
      wr(4'h8, 32'h01);
      check("coll_irq", {31'b0, irq_o}, 32'h1);
      rd(4'h8, 32'h01);
      check("coll_irq2", {31'b0, irq_o}, 32'h1);
      wr(4'h8, 32'h01);
      repeat (2) step();
      check("coll_clr", {31'b0, irq_o}, 32'h0);
      rd(4'h8, 32'h00);

      // Output pin must not raise events.
      wr(4'h0, 32'h01);
      wr(4'h7, 32'h01);
      gpio_in_i = 8'h00;
      repeat (4 + DB_LAT) step();
      gpio_in_i = 8'h01;
      repeat (4 + DB_LAT) step();
      rd(4'h8, 32'h00);
      check("out_pin_irq", {31'b0, irq_o}, 32'h0);

      // Pins held high through reset produce no rise event.
      rst = 1'b1;
      gpio_in_i = 8'hFF;
      repeat (3) step();
      rst = 1'b0;
      wr(4'h6, 32'hFF);
      repeat (6 + DB_LAT) step();
      rd(4'h8, 32'h00);
      rd(4'h2, 32'hFF);
      check("warm_irq", {31'b0, irq_o}, 32'h0);

`ifdef GPIO_DEBOUNCE_EN
      gpio_in_i = 8'hF7;
      repeat (4 + DB_LAT) step();
      wr(4'h8, 32'hFF);
      gpio_in_i = 8'hFF;
      repeat (10) step();
      gpio_in_i = 8'hF7;
      repeat (30) step();
      rd(4'h2, 32'hF7);
      rd(4'h8, 32'h00);
      gpio_in_i = 8'hFF;
      repeat (19) step();
      rd(4'h2, 32'hFF);
      gpio_in_i = 8'hF7;
      rd(4'h8, 32'h08);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
